// File: rtl/lbctrl_pkg.sv
// Shared state encodings and constants for the sprite line buffer controller.
// Build option: LBCTRL_XWRAP_EN makes render writes past the buffer end wrap to the start.
package lbctrl_pkg;

    localparam int unsigned LB_LEN_DEF = 192;
    localparam int unsigned AW_DEF     = 8;
    localparam logic [11:0] BACKDROP   = 12'hFFF;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LOAD,
        R_LATCH,
        R_WRITE
    } ren_state_e;

    typedef enum logic [2:0] {
        D_IDLE,
        D_LOAD,
        D_READ,
        D_CLEAR,
        D_DONE
    } rd_state_e;

endpackage

// File: rtl/lbctrl_bank_mux.sv
// Per-bank steering: the rendering bank takes the render sequencer's controls,
// the other bank takes the readout/clear sequencer's controls.
module lbctrl_bank_mux #(
    parameter int unsigned AW   = 8,
    parameter logic        BANK = 1'b0
) (
    input  logic          i_render_bank,
    input  logic          i_ren_load,
    input  logic          i_ren_ck,
    input  logic          i_ren_we,
    input  logic [AW-1:0] i_ren_addr,
    input  logic          i_rd_load,
    input  logic          i_rd_ck,
    input  logic          i_rd_we,
    input  logic          i_rd_clearing,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_load,
    output logic          o_ck,
    output logic          o_we,
    output logic          o_clearing,
    output logic [AW-1:0] o_addr_load
);

    logic w_sel_render;

    assign w_sel_render = (i_render_bank == BANK);

    always_comb begin
        o_load      = 1'b1;
        o_ck        = 1'b0;
        o_we        = 1'b1;
        o_clearing  = 1'b0;
        o_addr_load = '0;
        if (w_sel_render) begin
            o_load      = i_ren_load;
            o_ck        = i_ren_ck;
            o_we        = i_ren_we;
            o_addr_load = i_ren_addr;
        end else begin
            o_load      = i_rd_load;
            o_ck        = i_rd_ck;
            o_we        = i_rd_we;
            o_clearing  = i_rd_clearing;
            o_addr_load = i_rd_addr;
        end
    end

endmodule

// File: rtl/linebuffer_ctrl.sv
// Ping-pong sequencer for the two sprite line buffer banks (render vs. readout/clear).
// Build option: LBCTRL_XWRAP_EN wraps render writes at counter >= LB_LEN back into the buffer.
module linebuffer_ctrl
    import lbctrl_pkg::*;
#(
    parameter int unsigned LB_LEN = LB_LEN_DEF,
    parameter int unsigned AW     = AW_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce_pix,
    input  logic            i_line_start,
    input  logic            i_rd_active,
    input  logic            i_spr_start,
    input  logic [AW-1:0]   i_spr_xpos,
    input  logic            i_spr_pix_valid,
    input  logic            i_spr_pix_opaque,
    output logic            o_spr_ready,
    output logic            o_render_bank,
    output logic [1:0]      o_lb_load,
    output logic [1:0]      o_lb_ck,
    output logic [1:0]      o_lb_we,
    output logic [1:0]      o_lb_clearing,
    output logic [2*AW-1:0] o_lb_addr_load
);

    localparam logic [AW:0]   LEN_W  = LB_LEN[AW:0];
    localparam logic [AW-1:0] RD_END = LB_LEN[AW-1:0];

    // Set by the first LINE_START; until then neither sequencer may act.
    logic          r_armed;
    logic          r_render_bank;

    ren_state_e    r_ren_state, w_ren_state_d;
    logic [AW-1:0] r_ren_cnt, w_ren_cnt_d;
    logic          r_ren_load, w_ren_load_d;
    logic          r_ren_ck, w_ren_ck_d;
    logic          r_ren_we, w_ren_we_d;
    logic [AW-1:0] r_ren_addr, w_ren_addr_d;

    rd_state_e     r_rd_state, w_rd_state_d;
    logic [AW-1:0] r_rd_cnt, w_rd_cnt_d;
    logic          r_rd_load, w_rd_load_d;
    logic          r_rd_ck, w_rd_ck_d;
    logic          r_rd_we, w_rd_we_d;
    logic          r_rd_clr, w_rd_clr_d;

    logic          w_spr_ready;
    logic          w_in_range;

    assign w_spr_ready   = r_armed && (r_ren_state == R_IDLE);
    assign w_in_range    = ({1'b0, r_ren_cnt} < LEN_W);
    assign o_spr_ready   = w_spr_ready;
    assign o_render_bank = r_render_bank;

    // Controls are registered together with the state they belong to, so the
    // pulse for a decision appears during the cycle after that decision.
    always_comb begin
        w_ren_state_d = r_ren_state;
        w_ren_cnt_d   = r_ren_cnt;
        w_ren_load_d  = 1'b1;
        w_ren_ck_d    = 1'b0;
        w_ren_we_d    = 1'b1;
        w_ren_addr_d  = '0;
        if (i_line_start) begin
            w_ren_state_d = R_LOAD;
            w_ren_cnt_d   = '0;
            w_ren_load_d  = 1'b0;
            w_ren_ck_d    = 1'b1;
        end else begin
            unique case (r_ren_state)
                R_LOAD: w_ren_state_d = R_IDLE;
                R_IDLE: begin
                    if (w_spr_ready && i_spr_start) begin
                        w_ren_load_d = 1'b0;
                        w_ren_ck_d   = 1'b1;
                        w_ren_addr_d = i_spr_xpos;
                        w_ren_cnt_d  = i_spr_xpos;
                    end else if (w_spr_ready && i_spr_pix_valid) begin
                        if (!i_spr_pix_opaque) begin
                            w_ren_ck_d  = 1'b1;
                            w_ren_cnt_d = r_ren_cnt + 1'b1;
                        end else if (w_in_range) begin
                            w_ren_state_d = R_LATCH;
                        end else begin
`ifdef LBCTRL_XWRAP_EN
                            // Reload the bank counter inside the buffer before writing.
                            w_ren_state_d = R_LATCH;
                            w_ren_load_d  = 1'b0;
                            w_ren_ck_d    = 1'b1;
                            w_ren_addr_d  = r_ren_cnt - LEN_W[AW-1:0];
                            w_ren_cnt_d   = r_ren_cnt - LEN_W[AW-1:0];
`else
                            w_ren_ck_d  = 1'b1;
                            w_ren_cnt_d = r_ren_cnt + 1'b1;
`endif
                        end
                    end
                end
                R_LATCH: begin
                    w_ren_state_d = R_WRITE;
                    w_ren_we_d    = 1'b0;
                    w_ren_ck_d    = 1'b1;
                    w_ren_cnt_d   = r_ren_cnt + 1'b1;
                end
                R_WRITE: w_ren_state_d = R_IDLE;
                default: w_ren_state_d = R_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_state_d = r_rd_state;
        w_rd_cnt_d   = r_rd_cnt;
        w_rd_load_d  = 1'b1;
        w_rd_ck_d    = 1'b0;
        w_rd_we_d    = 1'b1;
        w_rd_clr_d   = 1'b0;
        if (i_line_start) begin
            w_rd_state_d = D_LOAD;
            w_rd_cnt_d   = '0;
            w_rd_load_d  = 1'b0;
            w_rd_ck_d    = 1'b1;
        end else begin
            unique case (r_rd_state)
                D_LOAD: w_rd_state_d = D_IDLE;
                D_IDLE: begin
                    if (r_armed && i_ce_pix && i_rd_active) begin
                        w_rd_state_d = D_READ;
                    end
                end
                D_READ: begin
                    w_rd_state_d = D_CLEAR;
                    w_rd_we_d    = 1'b0;
                    w_rd_clr_d   = 1'b1;
                    w_rd_ck_d    = 1'b1;
                    w_rd_cnt_d   = r_rd_cnt + 1'b1;
                end
                // Counter already points past the cleared address here.
                D_CLEAR: w_rd_state_d = (r_rd_cnt == RD_END) ? D_DONE : D_IDLE;
                D_DONE:  w_rd_state_d = D_DONE;
                default: w_rd_state_d = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_armed       <= 1'b0;
            r_render_bank <= 1'b0;
            r_ren_state   <= R_IDLE;
            r_ren_cnt     <= '0;
            r_ren_load    <= 1'b1;
            r_ren_ck      <= 1'b0;
            r_ren_we      <= 1'b1;
            r_ren_addr    <= '0;
            r_rd_state    <= D_IDLE;
            r_rd_cnt      <= '0;
            r_rd_load     <= 1'b1;
            r_rd_ck       <= 1'b0;
            r_rd_we       <= 1'b1;
            r_rd_clr      <= 1'b0;
        end else begin
            if (i_line_start) begin
                r_armed       <= 1'b1;
                r_render_bank <= ~r_render_bank;
            end
            r_ren_state <= w_ren_state_d;
            r_ren_cnt   <= w_ren_cnt_d;
            r_ren_load  <= w_ren_load_d;
            r_ren_ck    <= w_ren_ck_d;
            r_ren_we    <= w_ren_we_d;
            r_ren_addr  <= w_ren_addr_d;
            r_rd_state  <= w_rd_state_d;
            r_rd_cnt    <= w_rd_cnt_d;
            r_rd_load   <= w_rd_load_d;
            r_rd_ck     <= w_rd_ck_d;
            r_rd_we     <= w_rd_we_d;
            r_rd_clr    <= w_rd_clr_d;
        end
    end

    lbctrl_bank_mux #(
        .AW   (AW),
        .BANK (1'b0)
    ) u_bank0 (
        .i_render_bank (r_render_bank),
        .i_ren_load    (r_ren_load),
        .i_ren_ck      (r_ren_ck),
        .i_ren_we      (r_ren_we),
        .i_ren_addr    (r_ren_addr),
        .i_rd_load     (r_rd_load),
        .i_rd_ck       (r_rd_ck),
        .i_rd_we       (r_rd_we),
        .i_rd_clearing (r_rd_clr),
        .i_rd_addr     ({AW{1'b0}}),
        .o_load        (o_lb_load[0]),
        .o_ck          (o_lb_ck[0]),
        .o_we          (o_lb_we[0]),
        .o_clearing    (o_lb_clearing[0]),
        .o_addr_load   (o_lb_addr_load[AW-1:0])
    );

    lbctrl_bank_mux #(
        .AW   (AW),
        .BANK (1'b1)
    ) u_bank1 (
        .i_render_bank (r_render_bank),
        .i_ren_load    (r_ren_load),
        .i_ren_ck      (r_ren_ck),
        .i_ren_we      (r_ren_we),
        .i_ren_addr    (r_ren_addr),
        .i_rd_load     (r_rd_load),
        .i_rd_ck       (r_rd_ck),
        .i_rd_we       (r_rd_we),
        .i_rd_clearing (r_rd_clr),
        .i_rd_addr     ({AW{1'b0}}),
        .o_load        (o_lb_load[1]),
        .o_ck          (o_lb_ck[1]),
        .o_we          (o_lb_we[1]),
        .o_clearing    (o_lb_clearing[1]),
        .o_addr_load   (o_lb_addr_load[2*AW-1:AW])
    );

endmodule
